// File: rtl/mem_port_arbiter.sv
// Two-requester memory port: arbitrates an instruction fetch port and a load/store
// port onto a single word-wide memory bus with byte lanes, alignment checks and a wait timeout.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic [31:0] ls_rdata,
    output logic        ls_valid,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t         state, state_next;
    logic [CW-1:0]  wait_cnt;
    logic           owner;       // 1 = load/store port, 0 = fetch port
    logic           last_owner;
    logic           r_we;
    logic [1:0]     r_size;
    logic           r_uns;
    logic [1:0]     r_lo;

    logic pick_ls;
    logic ls_misaligned;
    logic timeout;
    logic any_req;
    logic unused_bits;

    assign unused_bits = ^if_addr[1:0];
    assign fsm_state   = state;
    assign any_req     = if_req | ls_req;

    // Ties go to whichever port did not own the bus last.
    assign pick_ls       = ls_req && (!if_req || !last_owner);
    assign ls_misaligned = (ls_size == 2'b01 && ls_addr[0]) ||
                           (ls_size[1] && ls_addr[1:0] != 2'b00);
    assign timeout       = (state == ACCESS) && !mem_ready &&
                           (wait_cnt == CW'(MAX_WAIT - 1));

    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   be_for = 4'b0001 << lo;
            2'b01:   be_for = 4'b0011 << {lo[1], 1'b0};
            default: be_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lanes_for(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   lanes_for = {4{w[7:0]}};
            2'b01:   lanes_for = {2{w[15:0]}};
            default: lanes_for = w;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] raw, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lo);
        logic [31:0] s;
        s = raw >> {lo, 3'b000};
        case (size)
            2'b00:   load_fmt = uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'b01:   load_fmt = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_fmt = s;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req)
                    state_next = (pick_ls && ls_misaligned) ? RESP : ACCESS;
            end
            ACCESS: begin
                if (mem_ready || timeout) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_lo       <= 2'b00;
            if_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_valid   <= 1'b0;
            ls_err     <= 1'b0;
            ls_rdata   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
        end else begin
            if_gnt   <= 1'b0;
            ls_gnt   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if_err   <= 1'b0;
            ls_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= pick_ls;
                        wait_cnt <= '0;
                        if (pick_ls) begin
                            ls_gnt <= 1'b1;
                            r_we   <= ls_we;
                            r_size <= ls_size;
                            r_uns  <= ls_unsigned;
                            r_lo   <= ls_addr[1:0];
                            if (ls_misaligned) begin
                                // Rejected without touching memory; response goes out with the grant.
                                ls_valid <= 1'b1;
                                ls_err   <= 1'b1;
                                ls_rdata <= '0;
                            end else begin
                                mem_addr  <= {ls_addr[31:2], 2'b00};
                                mem_be    <= be_for(ls_size, ls_addr[1:0]);
                                mem_wdata <= lanes_for(ls_size, ls_wdata);
                                mem_rd_en <= !ls_we;
                                mem_wr_en <= ls_we;
                            end
                        end else begin
                            if_gnt    <= 1'b1;
                            r_we      <= 1'b0;
                            r_size    <= 2'b10;
                            r_uns     <= 1'b0;
                            r_lo      <= 2'b00;
                            mem_addr  <= {if_addr[31:2], 2'b00};
                            mem_be    <= 4'b1111;
                            mem_rd_en <= 1'b1;
                            mem_wr_en <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready || timeout) begin
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        if (owner) begin
                            ls_valid <= 1'b1;
                            ls_err   <= !mem_ready;
                            ls_rdata <= (!mem_ready || r_we) ? 32'h0
                                        : load_fmt(mem_rdata, r_size, r_uns, r_lo);
                        end else begin
                            if_valid <= 1'b1;
                            if_err   <= !mem_ready;
                            if_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, loads, stores, misalignment,
// timeout, round-robin arbitration and reset during a stalled access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic [31:0] ls_rdata;
    logic        ls_valid;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rdata(ls_rdata),
        .ls_valid(ls_valid), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ls_setup(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        ls_req      = 1'b1;
        ls_we       = we;
        ls_size     = size;
        ls_unsigned = uns;
        ls_addr     = addr;
        ls_wdata    = wdata;
    endtask

    logic [1:0] exp_gnt;
    int         n;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0;
        ls_unsigned = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        check("reset_gnt", {if_gnt, ls_gnt}, 2'b00);
        check("reset_valid_err", {if_valid, if_err, ls_valid, ls_err}, 4'b0000);
        check("reset_mem_ctl", {mem_be, mem_rd_en, mem_wr_en}, 6'b0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_rdata", if_rdata | ls_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Fetch with memory answering in the first enabled cycle.
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("fetch_gnt", {if_gnt, ls_gnt}, 2'b10);
        check("fetch_addr", mem_addr, 32'h100);
        check("fetch_ctl", {mem_be, mem_rd_en, mem_wr_en}, 6'b1111_10);
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h13;
        tick();
        check("fetch_valid", {if_valid, if_err, if_gnt, mem_rd_en}, 4'b1000);
        check("fetch_rdata", if_rdata, 32'h13);
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("fetch_idle_valid", if_valid, 1'b0);
        check("fetch_rdata_hold", if_rdata, 32'h13);

        // Signed then unsigned byte load from the top lane.
        ls_setup(1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
        tick();
        check("lb_gnt", {if_gnt, ls_gnt}, 2'b01);
        check("lb_ctl", {mem_be, mem_rd_en, mem_wr_en}, 6'b1000_10);
        check("lb_addr", mem_addr, 32'h200);
        ls_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h80FF_FFFF;
        tick();
        check("lb_valid", {ls_valid, ls_err}, 2'b10);
        check("lb_rdata", ls_rdata, 32'hFFFF_FF80);
        mem_ready = 1'b0;
        tick();
        ls_setup(1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
        tick();
        check("lbu_gnt", ls_gnt, 1'b1);
        ls_req = 1'b0; mem_ready = 1'b1;
        tick();
        check("lbu_valid", {ls_valid, ls_err}, 2'b10);
        check("lbu_rdata", ls_rdata, 32'h0000_0080);
        mem_ready = 1'b0;
        tick();

        // Half store into the upper half-word.
        ls_setup(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234_ABCD);
        tick();
        check("sh_ctl", {mem_be, mem_rd_en, mem_wr_en}, 6'b1100_01);
        check("sh_addr", mem_addr, 32'h300);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        ls_req = 1'b0; mem_ready = 1'b1;
        tick();
        check("sh_valid", {ls_valid, ls_err}, 2'b10);
        check("sh_rdata", ls_rdata, 32'h0);
        mem_ready = 1'b0;
        tick();

        // Misaligned word load never reaches memory.
        ls_setup(1'b0, 2'b10, 1'b0, 32'h401, 32'h0);
        tick();
        check("mis_gnt_resp", {ls_gnt, ls_valid, ls_err}, 3'b111);
        check("mis_no_en", {mem_rd_en, mem_wr_en}, 2'b00);
        check("mis_rdata", ls_rdata, 32'h0);
        ls_req = 1'b0;
        tick();
        check("mis_after", {ls_valid, ls_err}, 2'b00);

        // Fetch against a memory that never answers.
        if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("to_gnt", {if_gnt, mem_rd_en}, 2'b11);
        if_req = 1'b0;
        n = 0;
        while (mem_rd_en === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("to_enable_cycles", n, 16);
        check("to_resp", {if_valid, if_err}, 2'b11);
        check("to_rdata", if_rdata, 32'h0);
        tick();

        // Round-robin with both ports requesting continuously from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h700;
        ls_setup(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        mem_rdata = 32'h0;
        for (int t = 0; t < 4; t++) begin
            exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("rr_gnt_%0d", t), {if_gnt, ls_gnt}, exp_gnt);
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            check($sformatf("rr_valid_%0d", t), {if_valid, ls_valid}, exp_gnt);
            tick();
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // Reset in the middle of a stalled store.
        ls_setup(1'b1, 2'b10, 1'b0, 32'h800, 32'h55);
        tick();
        check("rst_store_en", mem_wr_en, 1'b1);
        ls_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_async_ctl", {mem_be, mem_rd_en, mem_wr_en}, 6'b0);
        check("rst_async_bus", mem_addr | mem_wdata, 32'h0);
        check("rst_async_flags", {if_gnt, ls_gnt, if_valid, ls_valid, if_err, ls_err}, 6'b0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ls_valid === 1'b1) n++;
        end
        check("rst_no_ls_valid", n, 0);
        if_req = 1'b1; if_addr = 32'h900;
        tick();
        check("post_rst_gnt", {if_gnt, mem_rd_en}, 2'b11);
        check("post_rst_addr", mem_addr, 32'h900);
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check("post_rst_valid", {if_valid, if_err}, 2'b10);
        check("post_rst_rdata", if_rdata, 32'h1234_5678);
        mem_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
